mpu_matrix_loader: RTL and testbench
====================================

// Module: mpu_matrix_loader
// PURPOSE
//   Input stage of the MPU, directly upstream of the matrix adder. Accepts a
//   byte stream over a valid/ready handshake and assembles two DIM x DIM
//   operand matrices, A then B, in row-major order. It then holds both
//   matrices stable on flat buses for the adder until the consumer
//   acknowledges them.
// PARAMETERS
//   ELEM_WIDTH  8  bits per matrix element
//   DIM         5  rows = columns of each matrix (DIM*DIM elements per matrix)
// PORTS
//   clock           in   1                  system clock, all state on rising edge
//   reset           in   1                  synchronous, active-high reset
//   in_valid        in   1                  in_data carries an element
//   in_data         in   ELEM_WIDTH         element value
//   in_ready        out  1                  loader accepts an element this cycle
//   loading_b       out  1                  1 while filling matrix B
//   matrices_valid  out  1                  matrix_a and matrix_b complete and stable
//   matrices_ack    in   1                  consumer has taken the matrices
//   matrix_a        out  DIM*DIM*ELEM_WIDTH element (i,j) at [(i*DIM+j)*ELEM_WIDTH +: ELEM_WIDTH]
//   matrix_b        out  DIM*DIM*ELEM_WIDTH same packing as matrix_a
// BEHAVIOUR
//   - States: LOAD_A -> LOAD_B -> FULL -> LOAD_A. Element index idx counts
//     0..DIM*DIM-1, with row = idx/DIM and col = idx%DIM.
//   - Reset: state LOAD_A, idx 0, all matrix registers 0, matrices_valid 0,
//     loading_b 0. in_ready is forced to 0 while reset is high.
//   - in_ready = (state != FULL) && !reset. It is combinational from state.
//   - Beat: a beat occurs when in_valid && in_ready. The beat writes in_data
//     into element idx of the current matrix, and idx increments.
//   - End of matrix: on a beat at idx == DIM*DIM-1, idx wraps to 0.
//     LOAD_A advances to LOAD_B. LOAD_B advances to FULL.
//   - Without a beat, idx and the matrices hold. in_data is ignored when
//     in_valid is 0.
//   - matrices_valid rises in the cycle after the last B beat; its latency
//     from the final beat is 1 cycle. It is registered and equals (state == FULL).
//   - In FULL: in_ready = 0, and matrix_a and matrix_b are held unchanged.
//   - matrices_ack sampled high in FULL: the next state is LOAD_A, and
//     matrices_valid drops in the following cycle. matrices_ack is ignored
//     in any other state.
//   - Matrix contents are not cleared on ack. They are overwritten element
//     by element by the next load.
//   - loading_b is registered and equals (state == LOAD_B).
//   - The loader performs no arithmetic. Elements are stored bit-exact.
//     Overflow in the downstream adder is the adder's concern.
//   - Reset mid-operation, in any state, restarts at LOAD_A with idx 0 and
//     zeroed matrices. A partial load is discarded.
// CONFIGURATION
//   MPU_LOADER_ABORT_EN defined:
//     - Adds input port abort (1 bit).
//     - abort high in any state: the next state is LOAD_A, idx is 0, and
//       matrices_valid is 0.
//     - Matrix contents are retained.
//     - abort has priority over a simultaneous beat (the element is not
//       written, idx does not advance) and over a simultaneous matrices_ack.
//     - Reset has priority over abort.
//   MPU_LOADER_ABORT_EN undefined: the abort port does not exist. The only
//   way back to LOAD_A is ack from FULL, or reset.
// TESTING
//   1. Reset held 2 cycles -> in_ready 0 during reset, then in_ready 1;
//      matrices_valid 0, loading_b 0, matrix_a and matrix_b all zero.
//   2. 50 consecutive beats, A[k]=k, B[k]=100+k -> loading_b rises after
//      beat 25; matrices_valid 1 the cycle after beat 50; A(2,3)=13,
//      B(4,4)=124.
//   3. in_valid toggled every other cycle, plus extra in_valid while FULL
//      -> exactly 50 beats accepted; in_ready 0 in FULL; matrices unchanged
//      by the extra data.
//   4. Ack in FULL, then reload with A=0xFF and B=0x01 -> matrices_valid 0
//      one cycle after ack; second load overwrites all 50 elements; the
//      adder sees 0x00 in every position.
//   5. Reset asserted after 30 beats, then a full reload -> state restarts
//      at LOAD_A with idx 0; the final matrices hold only the post-reset data.
//   6. (MPU_LOADER_ABORT_EN) abort together with beat 10 -> element 9 not
//      written; the next accepted beat lands in A(0,0).

Source files
------------

// File: rtl/mpu_matrix_loader.sv
// MPU input stage: assembles two DIM x DIM operand matrices (A then B) from a byte stream.
// Optional abort input is enabled by defining MPU_LOADER_ABORT_EN.
module mpu_matrix_loader #(
  parameter int ELEM_WIDTH = 8,
  parameter int DIM        = 5
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic [ELEM_WIDTH-1:0]           in_data,
  output logic                            in_ready,
  output logic                            loading_b,
  output logic                            matrices_valid,
  input  logic                            matrices_ack,
`ifdef MPU_LOADER_ABORT_EN
  input  logic                            abort,
`endif
  output logic [DIM*DIM*ELEM_WIDTH-1:0]   matrix_a,
  output logic [DIM*DIM*ELEM_WIDTH-1:0]   matrix_b
);

  localparam int NUM_ELEM = DIM * DIM;
  localparam int MAT_W    = NUM_ELEM * ELEM_WIDTH;
  localparam int IDX_W    = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [MAT_W-1:0]   matrix_a_r;
  logic [MAT_W-1:0]   matrix_b_r;
  logic               valid_r;
  logic               loading_b_r;

  // Ready is combinational from state so a beat can be taken in the cycle after leaving FULL.
  assign in_ready       = (state_r != FULL) && !reset;
  assign loading_b      = loading_b_r;
  assign matrices_valid = valid_r;
  assign matrix_a       = matrix_a_r;
  assign matrix_b       = matrix_b_r;

  // Load FSM: element capture, index tracking and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= LOAD_A;
      idx_r       <= {IDX_W{1'b0}};
      matrix_a_r  <= {MAT_W{1'b0}};
      matrix_b_r  <= {MAT_W{1'b0}};
      valid_r     <= 1'b0;
      loading_b_r <= 1'b0;
    end
`ifdef MPU_LOADER_ABORT_EN
    // Abort drops any partial load but keeps the stored elements.
    else if (abort) begin
      state_r     <= LOAD_A;
      idx_r       <= {IDX_W{1'b0}};
      valid_r     <= 1'b0;
      loading_b_r <= 1'b0;
    end
`endif
    else begin
      case (state_r)
        LOAD_A: begin
          if (in_valid) begin
            for (int k = 0; k < NUM_ELEM; k++) begin
              if (idx_r == IDX_W'(k)) begin
                matrix_a_r[k*ELEM_WIDTH +: ELEM_WIDTH] <= in_data;
              end
            end
            if (idx_r == LAST_IDX) begin
              idx_r       <= {IDX_W{1'b0}};
              state_r     <= LOAD_B;
              loading_b_r <= 1'b1;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            for (int k = 0; k < NUM_ELEM; k++) begin
              if (idx_r == IDX_W'(k)) begin
                matrix_b_r[k*ELEM_WIDTH +: ELEM_WIDTH] <= in_data;
              end
            end
            if (idx_r == LAST_IDX) begin
              idx_r       <= {IDX_W{1'b0}};
              state_r     <= FULL;
              loading_b_r <= 1'b0;
              valid_r     <= 1'b1;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end
        end
        FULL: begin
          if (matrices_ack) begin
            state_r <= LOAD_A;
            valid_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= LOAD_A;
          idx_r       <= {IDX_W{1'b0}};
          valid_r     <= 1'b0;
          loading_b_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Self-checking bench for mpu_matrix_loader: randomized stimulus against a beat-count model.
module tb_mpu_matrix_loader;

  localparam int EW = 8;
  localparam int D  = 5;
  localparam int N  = D * D;
  localparam int MW = N * EW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [EW-1:0] in_data = 8'h00;
  logic          in_ready;
  logic          loading_b;
  logic          matrices_valid;
  logic          matrices_ack = 1'b0;
  logic          abort = 1'b0;
  logic [MW-1:0] matrix_a;
  logic [MW-1:0] matrix_b;

  int checks = 0;
  int errors = 0;

  // Reference model: beats taken in the current A+B load (0..2N-1), full flag, element arrays.
  int            beats = 0;
  bit            full = 1'b0;
  logic [EW-1:0] ma [N];
  logic [EW-1:0] mb [N];

  mpu_matrix_loader #(.ELEM_WIDTH(EW), .DIM(D)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .loading_b(loading_b),
    .matrices_valid(matrices_valid),
    .matrices_ack(matrices_ack),
`ifdef MPU_LOADER_ABORT_EN
    .abort(abort),
`endif
    .matrix_a(matrix_a),
    .matrix_b(matrix_b)
  );

  always #5 clock = ~clock;

  function automatic logic [MW-1:0] pack_mat(input bit sel_b);
    logic [MW-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*EW +: EW] = sel_b ? mb[k] : ma[k];
    return v;
  endfunction

  task automatic step(input logic v, input logic [EW-1:0] d, input logic ack,
                      input logic ab, input logic rst);
    in_valid = v; in_data = d; matrices_ack = ack; abort = ab; reset = rst;
    @(posedge clock);
    if (rst) begin
      beats = 0; full = 1'b0;
      for (int k = 0; k < N; k++) begin ma[k] = '0; mb[k] = '0; end
    end
`ifdef MPU_LOADER_ABORT_EN
    else if (ab) begin
      beats = 0; full = 1'b0;
    end
`endif
    else if (full) begin
      if (ack) begin full = 1'b0; beats = 0; end
    end else if (v) begin
      if (beats < N) ma[beats] = d; else mb[beats - N] = d;
      beats++;
      if (beats == 2 * N) begin full = 1'b1; beats = 0; end
    end
    #1;
  endtask

  task automatic test_reset;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_1 got %b want 0", in_ready); end
    step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_2 got %b want 0", in_ready); end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b want 1", in_ready); end
    checks++; if (matrices_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", matrices_valid); end
    checks++; if (loading_b !== 1'b0) begin errors++; $display("FAIL reset_loading_b got %b want 0", loading_b); end
    checks++; if (matrix_a !== '0) begin errors++; $display("FAIL reset_matrix_a got %h want 0", matrix_a); end
    checks++; if (matrix_b !== '0) begin errors++; $display("FAIL reset_matrix_b got %h want 0", matrix_b); end
  endtask

  task automatic test_sequential;
    for (int k = 0; k < 2 * N; k++) begin
      step(1'b1, (k < N) ? EW'(k) : EW'(100 + k - N), 1'b0, 1'b0, 1'b0);
      if (k == N - 2) begin
        checks++; if (loading_b !== 1'b0) begin errors++; $display("FAIL seq_loading_b_early got %b want 0", loading_b); end
      end
      if (k == N - 1) begin
        checks++; if (loading_b !== 1'b1) begin errors++; $display("FAIL seq_loading_b_rise got %b want 1", loading_b); end
      end
      if (k == 2 * N - 2) begin
        checks++; if (matrices_valid !== 1'b0) begin errors++; $display("FAIL seq_valid_early got %b want 0", matrices_valid); end
      end
    end
    checks++; if (matrices_valid !== 1'b1) begin errors++; $display("FAIL seq_valid got %b want 1", matrices_valid); end
    checks++; if (loading_b !== 1'b0) begin errors++; $display("FAIL seq_loading_b_fall got %b want 0", loading_b); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL seq_ready_full got %b want 0", in_ready); end
    checks++; if (matrix_a[(2*D+3)*EW +: EW] !== 8'd13) begin errors++; $display("FAIL seq_a23 got %0d want 13", matrix_a[(2*D+3)*EW +: EW]); end
    checks++; if (matrix_b[(4*D+4)*EW +: EW] !== 8'd124) begin errors++; $display("FAIL seq_b44 got %0d want 124", matrix_b[(4*D+4)*EW +: EW]); end
    checks++; if (matrix_a !== pack_mat(1'b0)) begin errors++; $display("FAIL seq_matrix_a got %h want %h", matrix_a, pack_mat(1'b0)); end
    checks++; if (matrix_b !== pack_mat(1'b1)) begin errors++; $display("FAIL seq_matrix_b got %h want %h", matrix_b, pack_mat(1'b1)); end
  endtask

  task automatic test_toggle;
    int accepted;
    int cyc;
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (matrices_valid !== 1'b0) begin errors++; $display("FAIL tog_ack_valid got %b want 0", matrices_valid); end
    accepted = 0;
    cyc = 0;
    while (!full && cyc < 300) begin
      if ((cyc % 2 == 0) && in_ready) accepted++;
      step((cyc % 2 == 0), EW'($urandom), 1'b0, 1'b0, 1'b0);
      cyc++;
    end
    checks++; if (!full) begin errors++; $display("FAIL tog_timeout got %0d cycles want load complete", cyc); end
    checks++; if (accepted !== 2 * N) begin errors++; $display("FAIL tog_beats got %0d want %0d", accepted, 2 * N); end
    for (int k = 0; k < 5; k++) begin
      step(1'b1, EW'($urandom), 1'b0, 1'b0, 1'b0);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL tog_full_ready got %b want 0", in_ready); end
      checks++; if (matrices_valid !== 1'b1) begin errors++; $display("FAIL tog_full_valid got %b want 1", matrices_valid); end
      checks++; if (matrix_a !== pack_mat(1'b0)) begin errors++; $display("FAIL tog_full_a got %h want %h", matrix_a, pack_mat(1'b0)); end
      checks++; if (matrix_b !== pack_mat(1'b1)) begin errors++; $display("FAIL tog_full_b got %h want %h", matrix_b, pack_mat(1'b1)); end
    end
  endtask

  task automatic test_ack_reload;
    logic [EW-1:0] s;
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checks++; if (matrices_valid !== 1'b0) begin errors++; $display("FAIL ack_valid_drop got %b want 0", matrices_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ack_ready got %b want 1", in_ready); end
    for (int k = 0; k < 2 * N; k++) step(1'b1, (k < N) ? 8'hFF : 8'h01, 1'b0, 1'b0, 1'b0);
    checks++; if (matrices_valid !== 1'b1) begin errors++; $display("FAIL reload_valid got %b want 1", matrices_valid); end
    for (int k = 0; k < N; k++) begin
      s = matrix_a[k*EW +: EW] + matrix_b[k*EW +: EW];
      checks++; if (s !== 8'h00) begin errors++; $display("FAIL reload_sum[%0d] got %h want 00", k, s); end
    end
    checks++; if (matrix_a !== pack_mat(1'b0)) begin errors++; $display("FAIL reload_a got %h want %h", matrix_a, pack_mat(1'b0)); end
  endtask

  task automatic test_reset_mid;
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) step(1'b1, EW'($urandom), 1'b0, 1'b0, 1'b0);
    checks++; if (loading_b !== 1'b1) begin errors++; $display("FAIL mid_loading_b got %b want 1", loading_b); end
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    checks++; if (matrix_a !== '0 || matrix_b !== '0) begin errors++; $display("FAIL mid_reset_clear got %h/%h want 0", matrix_a, matrix_b); end
    checks++; if (loading_b !== 1'b0) begin errors++; $display("FAIL mid_reset_loading_b got %b want 0", loading_b); end
    for (int k = 0; k < 2 * N; k++) begin
      step(1'b1, EW'($urandom), 1'b0, 1'b0, 1'b0);
      if (k == N - 2) begin
        checks++; if (loading_b !== 1'b0) begin errors++; $display("FAIL mid_idx_restart got %b want 0", loading_b); end
      end
    end
    checks++; if (matrices_valid !== 1'b1) begin errors++; $display("FAIL mid_valid got %b want 1", matrices_valid); end
    checks++; if (matrix_a !== pack_mat(1'b0)) begin errors++; $display("FAIL mid_a got %h want %h", matrix_a, pack_mat(1'b0)); end
    checks++; if (matrix_b !== pack_mat(1'b1)) begin errors++; $display("FAIL mid_b got %h want %h", matrix_b, pack_mat(1'b1)); end
  endtask

`ifdef MPU_LOADER_ABORT_EN
  task automatic test_abort;
    logic [EW-1:0] old9;
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) step(1'b1, EW'(200 + k), 1'b0, 1'b0, 1'b0);
    old9 = ma[9];
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    checks++; if (matrix_a[9*EW +: EW] !== old9) begin errors++; $display("FAIL abort_elem9 got %h want %h", matrix_a[9*EW +: EW], old9); end
    checks++; if (matrices_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", matrices_valid); end
    step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    checks++; if (matrix_a[0 +: EW] !== 8'h3C) begin errors++; $display("FAIL abort_restart got %h want 3c", matrix_a[0 +: EW]); end
    checks++; if (matrix_a !== pack_mat(1'b0)) begin errors++; $display("FAIL abort_a got %h want %h", matrix_a, pack_mat(1'b0)); end
  endtask
`endif

  task automatic test_random;
    logic v, a, ab;
    for (int c = 0; c < 600; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 3) == 0);
`ifdef MPU_LOADER_ABORT_EN
      ab = ($urandom_range(0, 40) == 0);
`else
      ab = 1'b0;
`endif
      checks++; if (in_ready !== !full) begin errors++; $display("FAIL rnd_ready c=%0d got %b want %b", c, in_ready, !full); end
      step(v, EW'($urandom), a, ab, 1'b0);
      checks++; if (matrices_valid !== full) begin errors++; $display("FAIL rnd_valid c=%0d got %b want %b", c, matrices_valid, full); end
      checks++; if (loading_b !== (!full && beats >= N)) begin errors++; $display("FAIL rnd_loading_b c=%0d got %b want %b", c, loading_b, (!full && beats >= N)); end
      checks++; if (matrix_a !== pack_mat(1'b0) || matrix_b !== pack_mat(1'b1)) begin
        errors++; $display("FAIL rnd_matrices c=%0d got %h/%h want %h/%h", c, matrix_a, matrix_b, pack_mat(1'b0), pack_mat(1'b1));
      end
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin ma[k] = '0; mb[k] = '0; end
    test_reset();
    test_sequential();
    test_toggle();
    test_ack_reload();
    test_reset_mid();
`ifdef MPU_LOADER_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
